// File: rtl/alu_op_decoder.sv
// alu_op_decoder
//
// Pipelined decode stage for RV32I/M ALU instructions. Each accepted
// instruction word is decoded into a 13-bit one-hot ALU op, register
// indices and an I-type immediate, then held in a two-entry skid buffer
// so that in_ready can be a plain flop while still sustaining one word
// per cycle.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_instr is the raw word
//   out_valid/out_ready   downstream handshake for the decoded fields
//   out_op                one-hot op (0 ADD .. 12 MULHU), zero if illegal
//   out_rd/rs1/rs2        register indices taken straight from the word
//   out_imm, out_use_imm  immediate and in2 select (1 = immediate)
//   out_illegal           word is not a supported ALU encoding
//   illegal_cnt           saturating count of accepted illegal words
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. A producer holding valid keeps its data
// stable until that edge; ready never depends combinationally on the
// other side's valid/ready.
//
// The FSM state is kept in the named signal `state` so checkers can bind
// to it directly.

module alu_op_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_op,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic        out_use_imm,
    output logic        out_illegal,
    output logic [15:0] illegal_cnt
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULH  = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    typedef struct packed {
        logic [12:0] op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } dec_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state;
    dec_t   main_q;
    dec_t   skid_q;
    dec_t   dec;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] op_idx;
    logic       legal;
    logic       accept;
    logic       pop;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Combinational decode of the incoming word.
    always_comb begin
        op_idx      = OP_ADD;
        legal       = 1'b0;
        dec         = '0;
        dec.rd      = in_instr[11:7];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];

        case (opcode)
            OPC_R: begin
                case (funct7)
                    7'b0000000: begin
                        legal = 1'b1;
                        case (funct3)
                            3'b000:  op_idx = OP_ADD;
                            3'b001:  op_idx = OP_SLL;
                            3'b010:  op_idx = OP_SLT;
                            3'b011:  op_idx = OP_SLTU;
                            3'b100:  op_idx = OP_XOR;
                            3'b101:  op_idx = OP_SRL;
                            3'b110:  op_idx = OP_OR;
                            default: op_idx = OP_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            legal  = 1'b1;
                            op_idx = OP_SUB;
                        end else if (funct3 == 3'b101) begin
                            legal  = 1'b1;
                            op_idx = OP_SRA;
                        end
                    end
                    7'b0000001: begin
                        if (funct3 == 3'b000) begin
                            legal  = 1'b1;
                            op_idx = OP_MUL;
                        end else if (funct3 == 3'b001) begin
                            legal  = 1'b1;
                            op_idx = OP_MULH;
                        end else if (funct3 == 3'b011) begin
                            legal  = 1'b1;
                            op_idx = OP_MULHU;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_I: begin
                dec.use_imm = 1'b1;
                dec.imm     = {{20{in_instr[31]}}, in_instr[31:20]};
                case (funct3)
                    3'b000: begin legal = 1'b1; op_idx = OP_ADD;  end
                    3'b010: begin legal = 1'b1; op_idx = OP_SLT;  end
                    3'b011: begin legal = 1'b1; op_idx = OP_SLTU; end
                    3'b100: begin legal = 1'b1; op_idx = OP_XOR;  end
                    3'b110: begin legal = 1'b1; op_idx = OP_OR;   end
                    3'b111: begin legal = 1'b1; op_idx = OP_AND;  end
                    3'b001: begin
                        // Shifts carry shamt in imm[4:0]; imm[11:5] picks the kind.
                        dec.imm = {27'b0, in_instr[24:20]};
                        if (funct7 == 7'b0000000) begin
                            legal  = 1'b1;
                            op_idx = OP_SLL;
                        end
                    end
                    default: begin
                        dec.imm = {27'b0, in_instr[24:20]};
                        if (funct7 == 7'b0000000) begin
                            legal  = 1'b1;
                            op_idx = OP_SRL;
                        end else if (funct7 == 7'b0100000) begin
                            legal  = 1'b1;
                            op_idx = OP_SRA;
                        end
                    end
                endcase
            end
            default: legal = 1'b0;
        endcase

        // Illegal words keep only their index fields.
        if (legal) begin
            dec.op = 13'd1 << op_idx;
        end else begin
            dec.op      = '0;
            dec.imm     = '0;
            dec.use_imm = 1'b0;
        end
        dec.illegal = ~legal;
    end

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // Skid-buffer FSM. in_ready and out_valid are registered from the
    // next state, so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            illegal_cnt <= '0;
        end else begin
            if (accept && dec.illegal && (illegal_cnt != 16'hFFFF)) begin
                illegal_cnt <= illegal_cnt + 16'd1;
            end

            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        main_q    <= dec;
                        state     <= S_ONE;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && pop) begin
                        main_q <= dec;
                    end else if (accept) begin
                        // Main is stalled: park the new word in the skid slot.
                        skid_q   <= dec;
                        state    <= S_TWO;
                        in_ready <= 1'b0;
                    end else if (pop) begin
                        state     <= S_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                S_TWO: begin
                    // in_ready is 0 here, so only a pop can happen.
                    if (pop) begin
                        main_q   <= skid_q;
                        state    <= S_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_op      = main_q.op;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_imm     = main_q.imm;
    assign out_use_imm = main_q.use_imm;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Testbench for alu_op_decoder: directed decode cases, backpressure,
// counter saturation and a random valid/ready stream checked against a
// table-driven reference decoder and an expected-output queue.

module tb_alu_op_decoder;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_op;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic        out_illegal;
    logic [15:0] illegal_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_op_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_use_imm (out_use_imm),
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [12:0] op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic        ill;
    } exp_t;

    localparam int W = 62;
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    // Reference op tables: R-type keyed by {funct7, funct3}, I-type
    // non-shift ops keyed by funct3. Value is the one-hot bit number.
    int r_tab[logic [9:0]];
    int i_tab[logic [2:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        int idx;
        int v;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.rd = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        idx = -1;
        if (opc == 7'h33) begin
            if (r_tab.exists({f7, f3})) idx = r_tab[{f7, f3}];
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                if (f7 == 7'h00) idx = (f3 == 3'd1) ? 5 : 6;
                else if (f7 == 7'h20 && f3 == 3'd5) idx = 7;
                e.imm = {27'b0, w[24:20]};
            end else begin
                idx = i_tab[f3];
                v = int'(w[31:20]);
                if (v >= 2048) v = v - 4096;
                e.imm = v;
            end
            e.use_imm = 1'b1;
        end
        if (idx < 0) begin
            e.ill = 1'b1;
            e.imm = '0;
            e.use_imm = 1'b0;
        end else begin
            e.op = 13'(1 << idx);
        end
        return e;
    endfunction

    task automatic compare_out(input exp_t e);
        check("op", 64'(out_op), 64'(e.op));
        check("rd", 64'(out_rd), 64'(e.rd));
        check("rs1", 64'(out_rs1), 64'(e.rs1));
        check("rs2", 64'(out_rs2), 64'(e.rs2));
        check("illegal", 64'(out_illegal), 64'(e.ill));
        if (!e.ill) begin
            check("imm", 64'(out_imm), 64'(e.imm));
            check("use_imm", 64'(out_use_imm), 64'(e.use_imm));
        end
    endtask

    // ---------------- driver tasks ----------------
    // One cycle: drive at the falling edge, check occupancy flags, score a
    // pop that will happen at the next rising edge, record an accept.
    task automatic step(input logic v, input logic [31:0] w, input logic rdy, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_instr = w;
        out_ready = rdy;
        check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        acc = v && in_ready;
        if (out_valid && rdy) begin
            check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compare_out(e);
            end
        end
        if (acc) begin
            e = ref_decode(w);
            exp_q.push_back(e);
            if (e.ill && model_cnt < 65535) model_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_instr = $urandom;
        out_ready = 1'($urandom_range(0, 1));
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_cnt", 64'(illegal_cnt), 64'd0);
        check("rst_op", 64'(out_op), 64'd0);
        check("rst_rd", 64'(out_rd), 64'd0);
        check("rst_rs1", 64'(out_rs1), 64'd0);
        check("rst_rs2", 64'(out_rs2), 64'd0);
        check("rst_imm", 64'(out_imm), 64'd0);
        check("rst_use_imm", 64'(out_use_imm), 64'd0);
        check("rst_illegal", 64'(out_illegal), 64'd0);
        exp_q.delete();
        model_cnt = 0;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] w, input logic [12:0] eop,
                            input logic [4:0] erd, input logic [4:0] ers1, input logic [4:0] ers2,
                            input logic [31:0] eimm, input logic euse, input logic eill);
        logic a;
        step(1'b1, w, 1'b0, a);
        check({tag, "_acc"}, 64'(a), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_op"}, 64'(out_op), 64'(eop));
        check({tag, "_rd"}, 64'(out_rd), 64'(erd));
        check({tag, "_rs1"}, 64'(out_rs1), 64'(ers1));
        check({tag, "_rs2"}, 64'(out_rs2), 64'(ers2));
        check({tag, "_illegal"}, 64'(out_illegal), 64'(eill));
        if (!eill) begin
            check({tag, "_imm"}, 64'(out_imm), 64'(eimm));
            check({tag, "_use_imm"}, 64'(out_use_imm), 64'(euse));
        end
        step(1'b0, 32'h0, 1'b1, a);
    endtask

    function automatic logic [31:0] add_rd(input int rd);
        return 32'h00208033 | (32'(rd) << 7);
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        logic [6:0] f7s[3];
        int k;
        f7s = '{7'h00, 7'h20, 7'h01};
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k <= 3) begin
            w[6:0] = 7'h33;
            w[31:25] = f7s[$urandom_range(0, 2)];
        end else if (k <= 7) begin
            w[6:0] = 7'h13;
            if ($urandom_range(0, 2) != 0) w[31:25] = f7s[$urandom_range(0, 1)];
        end else if (k == 8) begin
            w[6:0] = 7'h33;
        end
        return w;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic a;
        int sent;
        int acc_n;
        logic [31:0] w;

        r_tab[{7'h00, 3'd0}] = 0;  r_tab[{7'h00, 3'd1}] = 5;
        r_tab[{7'h00, 3'd2}] = 8;  r_tab[{7'h00, 3'd3}] = 9;
        r_tab[{7'h00, 3'd4}] = 4;  r_tab[{7'h00, 3'd5}] = 6;
        r_tab[{7'h00, 3'd6}] = 3;  r_tab[{7'h00, 3'd7}] = 2;
        r_tab[{7'h20, 3'd0}] = 1;  r_tab[{7'h20, 3'd5}] = 7;
        r_tab[{7'h01, 3'd0}] = 10; r_tab[{7'h01, 3'd1}] = 11;
        r_tab[{7'h01, 3'd3}] = 12;
        i_tab[3'd0] = 0; i_tab[3'd2] = 8; i_tab[3'd3] = 9;
        i_tab[3'd4] = 4; i_tab[3'd6] = 3; i_tab[3'd7] = 2;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        out_ready = 1'b0;

        do_reset();

        // Directed decodes.
        directed("add",  32'h002081B3, 13'd1,    5'd3, 5'd1, 5'd2, 32'd0,        1'b0, 1'b0);
        directed("sub",  32'h402081B3, 13'd2,    5'd3, 5'd1, 5'd2, 32'd0,        1'b0, 1'b0);
        directed("mul",  32'h023100B3, 13'd1024, 5'd1, 5'd2, 5'd3, 32'd0,        1'b0, 1'b0);
        directed("addi", 32'hFFF00293, 13'd1,    5'd5, 5'd0, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b0);
        directed("srai", 32'h4030D093, 13'd128,  5'd1, 5'd1, 5'd3, 32'd3,        1'b1, 1'b0);
        directed("ill0", 32'h00000000, 13'd0,    5'd0, 5'd0, 5'd0, 32'd0,        1'b0, 1'b1);
        directed("ill1", 32'h4020F1B3, 13'd0,    5'd3, 5'd1, 5'd2, 32'd0,        1'b0, 1'b1);
        @(negedge clk);
        check("illegal_cnt_2", 64'(illegal_cnt), 64'd2);

        // Backpressure: five ADDs with out_ready low, then drain.
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, add_rd(sent + 1), 1'b0, a);
            if (a) sent++;
        end
        check("bp_accepted", 64'(sent), 64'd2);
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        for (int c = 0; c < 40 && (sent < 5 || exp_q.size() > 0); c++) begin
            step(sent < 5, add_rd(sent + 1), 1'b1, a);
            if (a) sent++;
        end
        check("bp_drained", 64'(sent == 5 && exp_q.size() == 0), 64'd1);

        // Random valid/ready stream of mixed words.
        acc_n = 0;
        for (int c = 0; c < 20000 && acc_n < 1000; c++) begin
            w = gen_word();
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0, a);
            if (a) acc_n++;
        end
        check("rand_accepted", 64'(acc_n), 64'd1000);
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) step(1'b0, 32'h0, 1'b1, a);
        @(negedge clk);
        check("rand_cnt", 64'(illegal_cnt), 64'(model_cnt));
        check("rand_empty", 64'(out_valid), 64'd0);

        // Fill both entries, then reset mid-operation.
        step(1'b1, add_rd(7), 1'b0, a);
        step(1'b1, add_rd(8), 1'b0, a);
        step(1'b1, add_rd(9), 1'b0, a);
        do_reset();

        // Saturation of the illegal counter.
        for (int c = 0; c < 65540; c++) step(1'b1, 32'h0, 1'b1, a);
        step(1'b0, 32'h0, 1'b1, a);
        @(negedge clk);
        check("sat_cnt", 64'(illegal_cnt), 64'hFFFF);
        check("sat_model", 64'(illegal_cnt), 64'(model_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
